bfly_tm: RTL and testbench

//  Time-multiplexed radix-2 DIT butterfly: z1 = a + b*w, z2 = a - b*w, complex fixed point.

---
 rtl/bfly_tm_if.sv | 41 ++++
 rtl/bfly_tm.sv | 188 ++++++++++++++++++
 tb/tb_bfly_tm.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bfly_tm_if.sv
// ---------------------------------------------------------------------------
// bfly_tm_if
//   Bundle for the time-multiplexed butterfly: operand handshake on the
//   input side and the real/imag beat stream on the output side.
//
//   in_valid / in_ready   operand handshake (accept = in_valid & in_ready)
//   a_r,a_i,b_r,b_i       complex operands a and b (signed, data_width)
//   w_r,w_i               twiddle, Q(FRAC_BITS) signed
//   out_data              {z2 part, z1 part}, real or imag per out_sel
//   out_en                out_data valid this cycle
//   out_sel               0 = real parts, 1 = imaginary parts
//   out_last              marks the imaginary beat (butterfly complete)
//
//   master: operand producer / beat consumer.  slave: the butterfly.
// ---------------------------------------------------------------------------
interface bfly_tm_if #(
  parameter int data_width = 8
);
  logic                           in_valid;
  logic                           in_ready;
  logic signed [data_width-1:0]   a_r;
  logic signed [data_width-1:0]   a_i;
  logic signed [data_width-1:0]   b_r;
  logic signed [data_width-1:0]   b_i;
  logic signed [data_width-1:0]   w_r;
  logic signed [data_width-1:0]   w_i;
  logic        [2*data_width-1:0] out_data;
  logic                           out_en;
  logic                           out_sel;
  logic                           out_last;

  modport master (
    output in_valid, a_r, a_i, b_r, b_i, w_r, w_i,
    input  in_ready, out_data, out_en, out_sel, out_last
  );

  modport slave (
    input  in_valid, a_r, a_i, b_r, b_i, w_r, w_i,
    output in_ready, out_data, out_en, out_sel, out_last
  );
endinterface

// File: rtl/bfly_tm.sv
// ---------------------------------------------------------------------------
// bfly_tm
//   Time-multiplexed radix-2 DIT butterfly, z1 = a + b*w, z2 = a - b*w.
//   One operand set is accepted every two cycles; the real parts are
//   computed in the RE cycle and the imaginary parts in the IM cycle on a
//   single pair of multipliers, and each result is registered as one beat.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous reset, active low
//     bus        bfly_tm_if.slave (operand handshake in, beat stream out)
//
//   Parameters
//     data_width operand/result width (signed two's complement)
//     FRAC_BITS  fractional bits of the twiddle
//     SCALE      1: halve both outputs before saturation, 0: saturate only
// ---------------------------------------------------------------------------
module bfly_tm #(
  parameter int data_width = 8,
  parameter int FRAC_BITS  = 6,
  parameter int SCALE      = 0
) (
  input  logic     clk,
  input  logic     rst,
  bfly_tm_if.slave bus
);

  localparam int DW = data_width;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RE   = 2'd1;
  localparam logic [1:0] IM   = 2'd2;

  logic [1:0] state;
  logic       accept;

  logic signed [DW-1:0] ar_p0;
  logic signed [DW-1:0] ai_p0;
  logic signed [DW-1:0] br_p0;
  logic signed [DW-1:0] bi_p0;
  logic signed [DW-1:0] wr_p0;
  logic signed [DW-1:0] wi_p0;

  logic                   is_im;
  logic signed [DW-1:0]   a_sel;
  logic signed [DW-1:0]   wbr_sel;
  logic signed [DW-1:0]   wbi_sel;
  logic signed [2*DW-1:0] prod_br;
  logic signed [2*DW-1:0] prod_bi;
  logic signed [2*DW:0]   psum;
  logic signed [2*DW:0]   pshift;
  logic signed [DW:0]     twid;
  logic signed [DW+1:0]   a_ext;
  logic signed [DW+1:0]   t_ext;
  logic signed [DW-1:0]   z1;
  logic signed [DW-1:0]   z2;

  logic [2*DW-1:0] data_p1;
  logic            vld_p1;
  logic            sel_p1;
  logic            last_p1;

  // Sign-extend a DW operand to product width so the multiply is exact.
  function automatic logic signed [2*DW-1:0] sext_prod(input logic signed [DW-1:0] v);
    return $signed({{DW{v[DW-1]}}, v});
  endfunction

  // Sign-extend a product by one bit so the sum/difference cannot wrap.
  function automatic logic signed [2*DW:0] sext_sum(input logic signed [2*DW-1:0] v);
    return $signed({v[2*DW-1], v});
  endfunction

  // Clamp the shifted twiddle product to DW+1 bits.
  function automatic logic signed [DW:0] sat_twid(input logic signed [2*DW:0] v);
    if (v[2*DW:DW] == {(DW+1){v[2*DW]}}) begin
      return v[DW:0];
    end else if (v[2*DW]) begin
      return {1'b1, {DW{1'b0}}};
    end else begin
      return {1'b0, {DW{1'b1}}};
    end
  endfunction

  // Optional halving, then clamp the DW+2 bit butterfly sum to DW bits.
  function automatic logic signed [DW-1:0] sat_out(input logic signed [DW+1:0] s);
    logic signed [DW+1:0] v;
    v = (SCALE != 0) ? (s >>> 1) : s;
    if (v[DW+1:DW-1] == {3{v[DW+1]}}) begin
      return v[DW-1:0];
    end else if (v[DW+1]) begin
      return {1'b1, {(DW-1){1'b0}}};
    end else begin
      return {1'b0, {(DW-1){1'b1}}};
    end
  endfunction

  assign bus.in_ready = (state != RE);
  assign accept       = bus.in_valid & bus.in_ready;

  // Control: IDLE -> RE on accept, RE -> IM, IM -> RE on accept else IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= accept ? RE : IDLE;
        RE:      state <= IM;
        IM:      state <= accept ? RE : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p0: operand capture on accept ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar_p0 <= '0;
      ai_p0 <= '0;
      br_p0 <= '0;
      bi_p0 <= '0;
      wr_p0 <= '0;
      wi_p0 <= '0;
    end else if (accept) begin
      ar_p0 <= bus.a_r;
      ai_p0 <= bus.a_i;
      br_p0 <= bus.b_r;
      bi_p0 <= bus.b_i;
      wr_p0 <= bus.w_r;
      wi_p0 <= bus.w_i;
    end
  end

  // One multiplier pair serves both halves: in RE it forms b_r*w_r - b_i*w_i,
  // in IM the twiddle halves swap to form b_r*w_i + b_i*w_r.
  always_comb begin
    is_im   = (state == IM);
    a_sel   = is_im ? ai_p0 : ar_p0;
    wbr_sel = is_im ? wi_p0 : wr_p0;
    wbi_sel = is_im ? wr_p0 : wi_p0;
    prod_br = sext_prod(br_p0) * sext_prod(wbr_sel);
    prod_bi = sext_prod(bi_p0) * sext_prod(wbi_sel);
    psum    = is_im ? (sext_sum(prod_br) + sext_sum(prod_bi))
                    : (sext_sum(prod_br) - sext_sum(prod_bi));
    pshift  = psum >>> FRAC_BITS;
    twid    = sat_twid(pshift);
    a_ext   = $signed({{2{a_sel[DW-1]}}, a_sel});
    t_ext   = $signed({twid[DW], twid});
    z1      = sat_out(a_ext + t_ext);
    z2      = sat_out(a_ext - t_ext);
  end

  // ---- stage p1: registered beat ----
  // out_data holds its previous value on idle cycles; strobes drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      sel_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      case (state)
        RE: begin
          data_p1 <= {z2, z1};
          vld_p1  <= 1'b1;
          sel_p1  <= 1'b0;
          last_p1 <= 1'b0;
        end
        IM: begin
          data_p1 <= {z2, z1};
          vld_p1  <= 1'b1;
          sel_p1  <= 1'b1;
          last_p1 <= 1'b1;
        end
        default: begin
          vld_p1  <= 1'b0;
          sel_p1  <= 1'b0;
          last_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_data = data_p1;
  assign bus.out_en   = vld_p1;
  assign bus.out_sel  = sel_p1;
  assign bus.out_last = last_p1;

endmodule

// File: tb/tb_bfly_tm.sv
// ---------------------------------------------------------------------------
// tb_bfly_tm
//   Drives a SCALE=0 and a SCALE=1 instance with the same operand stream and
//   checks every cycle against a plain-integer butterfly model with a queue
//   of expected beats stamped by clock edge.
// ---------------------------------------------------------------------------
module tb_bfly_tm;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bfly_tm_if #(.data_width(DW)) if0 ();
  bfly_tm_if #(.data_width(DW)) if1 ();

  bfly_tm #(.data_width(DW), .FRAC_BITS(6), .SCALE(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  bfly_tm #(.data_width(DW), .FRAC_BITS(6), .SCALE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          edge_no;
    logic [15:0] d0;
    logic [15:0] d1;
    bit          sel;
  } beat_t;

  beat_t       q[$];
  int          edge_cnt = 0;
  int          acc_edge = -10;
  logic [15:0] last_d0 = '0;
  logic [15:0] last_d1 = '0;
  int          run = 0;
  int          max_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Butterfly half straight from the arithmetic rules: {z2, z1}.
  function automatic logic [15:0] bfly_ref(input int ar, input int ai, input int br,
                                           input int bi, input int wr, input int wi,
                                           input bit im, input bit sc);
    int t, a, z1, z2;
    if (im) t = br * wi + bi * wr;
    else    t = br * wr - bi * wi;
    t  = t >>> 6;
    t  = clamp(t, -256, 255);
    a  = im ? ai : ar;
    z1 = a + t;
    z2 = a - t;
    if (sc) begin
      z1 = z1 >>> 1;
      z2 = z2 >>> 1;
    end
    z1 = clamp(z1, -128, 127);
    z2 = clamp(z2, -128, 127);
    return {z2[7:0], z1[7:0]};
  endfunction

  // Model update on rising edges, output comparison on falling edges.
  always @(clk) begin
    if (clk) begin
      edge_cnt++;
      if (rst && if0.in_valid && if0.in_ready) begin
        int ar, ai, br, bi, wr, wi;
        ar = int'(if0.a_r); ai = int'(if0.a_i);
        br = int'(if0.b_r); bi = int'(if0.b_i);
        wr = int'(if0.w_r); wi = int'(if0.w_i);
        q.push_back('{edge_cnt + 1, bfly_ref(ar, ai, br, bi, wr, wi, 1'b0, 1'b0),
                      bfly_ref(ar, ai, br, bi, wr, wi, 1'b0, 1'b1), 1'b0});
        q.push_back('{edge_cnt + 2, bfly_ref(ar, ai, br, bi, wr, wi, 1'b1, 1'b0),
                      bfly_ref(ar, ai, br, bi, wr, wi, 1'b1, 1'b1), 1'b1});
        acc_edge = edge_cnt;
      end
    end else begin
      if (!rst) begin
        q.delete();
        acc_edge = -10;
        last_d0  = '0;
        last_d1  = '0;
        chk("rst_en0",   32'(if0.out_en),   32'd0);
        chk("rst_en1",   32'(if1.out_en),   32'd0);
        chk("rst_data0", 32'(if0.out_data), 32'd0);
        chk("rst_data1", 32'(if1.out_data), 32'd0);
        chk("rst_sel0",  32'(if0.out_sel),  32'd0);
        chk("rst_last0", 32'(if0.out_last), 32'd0);
        chk("rst_ready", 32'(if0.in_ready), 32'd1);
      end else begin
        bit exp_en;
        exp_en = (q.size() > 0) && (q[0].edge_no == edge_cnt);
        chk("ready0", 32'(if0.in_ready), 32'(acc_edge != edge_cnt));
        chk("ready1", 32'(if1.in_ready), 32'(acc_edge != edge_cnt));
        chk("en0", 32'(if0.out_en), 32'(exp_en));
        chk("en1", 32'(if1.out_en), 32'(exp_en));
        if (exp_en) begin
          chk("data0", 32'(if0.out_data), 32'(q[0].d0));
          chk("data1", 32'(if1.out_data), 32'(q[0].d1));
          chk("sel0",  32'(if0.out_sel),  32'(q[0].sel));
          chk("last0", 32'(if0.out_last), 32'(q[0].sel));
          chk("sel1",  32'(if1.out_sel),  32'(q[0].sel));
          chk("last1", 32'(if1.out_last), 32'(q[0].sel));
          last_d0 = q[0].d0;
          last_d1 = q[0].d1;
          void'(q.pop_front());
        end else begin
          chk("hold0", 32'(if0.out_data), 32'(last_d0));
          chk("hold1", 32'(if1.out_data), 32'(last_d1));
        end
        while (q.size() > 0 && q[0].edge_no <= edge_cnt) void'(q.pop_front());
      end
      run = if0.out_en ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
  end

  task automatic set_in(input bit v, input int ar, input int ai, input int br,
                        input int bi, input int wr, input int wi);
    if0.in_valid = v;     if1.in_valid = v;
    if0.a_r = 8'(ar);     if1.a_r = 8'(ar);
    if0.a_i = 8'(ai);     if1.a_i = 8'(ai);
    if0.b_r = 8'(br);     if1.b_r = 8'(br);
    if0.b_i = 8'(bi);     if1.b_i = 8'(bi);
    if0.w_r = 8'(wr);     if1.w_r = 8'(wr);
    if0.w_i = 8'(wi);     if1.w_i = 8'(wi);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic put(input int ar, input int ai, input int br,
                     input int bi, input int wr, input int wi);
    int guard;
    set_in(1'b1, ar, ai, br, bi, wr, wi);
    guard = 0;
    while (!if0.in_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8) begin
      errors++;
      $display("FAIL accept_timeout got in_ready=0 want 1 within 8 cycles");
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    if0.in_valid = 1'b0;
    if1.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic int rnd();
    case ($urandom_range(0, 5))
      0:       return -128;
      1:       return 127;
      2:       return 64;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  initial begin
    set_in(1'b0, 0, 0, 0, 0, 0, 0);

    // Hand-computed pins on the model itself.
    chk("lit1_re",  32'(bfly_ref(10, 20, 30, -40, 64, 0, 1'b0, 1'b0)), 32'h0000_EC28);
    chk("lit1_im",  32'(bfly_ref(10, 20, 30, -40, 64, 0, 1'b1, 1'b0)), 32'h0000_3CEC);
    chk("lit2_re",  32'(bfly_ref(10, 20, 30, -40, 0, -64, 1'b0, 1'b0)), 32'h0000_32E2);
    chk("lit2_im",  32'(bfly_ref(10, 20, 30, -40, 0, -64, 1'b1, 1'b0)), 32'h0000_32F6);
    chk("lit3_re",  32'(bfly_ref(100, -100, 100, 100, 64, 0, 1'b0, 1'b0)), 32'h0000_007F);
    chk("lit3_im",  32'(bfly_ref(100, -100, 100, 100, 64, 0, 1'b1, 1'b0)), 32'h0000_8000);
    chk("lit3s_re", 32'(bfly_ref(100, -100, 100, 100, 64, 0, 1'b0, 1'b1)), 32'h0000_0064);
    chk("lit3s_im", 32'(bfly_ref(100, -100, 100, 100, 64, 0, 1'b1, 1'b1)), 32'h0000_9C00);
    chk("lit4a_re", 32'(bfly_ref(0, 0, 1, 0, 32, 0, 1'b0, 1'b0)), 32'h0000_0000);
    chk("lit4b_re", 32'(bfly_ref(0, 0, -1, 0, 32, 0, 1'b0, 1'b0)), 32'h0000_01FF);

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("init_en",    32'(if0.out_en),   32'd0);
    chk("init_data",  32'(if0.out_data), 32'd0);
    chk("init_ready", 32'(if0.in_ready), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // Directed vectors, each isolated.
    put(10, 20, 30, -40, 64, 0);      idle(4);
    put(10, 20, 30, -40, 0, -64);     idle(4);
    put(100, -100, 100, 100, 64, 0);  idle(4);
    put(0, 0, 1, 0, 32, 0);           idle(4);
    put(0, 0, -1, 0, 32, 0);          idle(4);
    put(-128, 127, -128, -128, -128, -128); idle(4);

    // Three back-to-back butterflies: six consecutive beats.
    max_run = 0;
    put(1, 2, 3, 4, 64, 0);
    put(-5, 6, 7, -8, 0, 64);
    put(50, -60, 70, 80, 45, -45);
    idle(5);
    chk("burst_run", 32'(max_run), 32'd6);

    // Randomized stream with random gaps.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) put(rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
      else idle($urandom_range(1, 3));
    end
    idle(4);

    // Reset during the RE cycle: pending butterfly dropped.
    put(10, 20, 30, -40, 64, 0);
    if0.in_valid = 1'b0;
    if1.in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_en",    32'(if0.out_en),   32'd0);
    chk("mid_rst_data",  32'(if0.out_data), 32'd0);
    chk("mid_rst_ready", 32'(if0.in_ready), 32'd1);
    chk("mid_rst_data1", 32'(if1.out_data), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    max_run = 0;
    idle(6);
    chk("post_rst_no_beat", 32'(max_run), 32'd0);

    put(-7, 9, 100, -3, 64, 64);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
